// File: rtl/daq_pkg.sv
// Shared command codes, default frame delimiters and state encoding for the DAQ frame sequencer.
`timescale 1ns/1ps
package daq_pkg;

  localparam logic [7:0] CMD_START = 8'hFF;
  localparam logic [7:0] CMD_RESET = 8'hC0;
  localparam logic [7:0] CMD_CLOSE = 8'hC7;

  localparam logic [31:0] DEF_HEAD_WORD = 32'hAAAAAAAA;
  localparam logic [31:0] DEF_TAIL_WORD = 32'hF0F0F0F0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_HEAD    = 2'd1;
  localparam state_t ST_PAYLOAD = 2'd2;
  localparam state_t ST_TAIL    = 2'd3;

  // Payload word k carries the pair {2k+1, 2k+2}.
  function automatic logic [31:0] payload_word(input logic [7:0] k);
    logic [15:0] k2;
    k2 = {7'd0, k, 1'b0};
    return {k2 + 16'd1, k2 + 16'd2};
  endfunction

endpackage

// File: rtl/daq_pacer.sv
// Free-running write-slot counter: tick is high one cycle in every 2^PACE_LOG2.
`timescale 1ns/1ps
module daq_pacer #(
  parameter int unsigned PACE_LOG2 = 5
) (
  input  logic bus_clk,
  input  logic rst_n,
  output logic tick
);

  generate
    if (PACE_LOG2 == 0) begin : g_every
      assign tick = 1'b1;
    end else begin : g_cnt
      logic [PACE_LOG2-1:0] cnt;

      always_ff @(posedge bus_clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + PACE_LOG2'(1);
      end

      assign tick = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/daq_frame_sequencer.sv
// Paced HEAD/PAYLOAD/TAIL frame generator for the read_32 capture FIFO, driven by command bytes.
// Build option DAQ_OVERFLOW_STOP_EN: stop writing and report EOF once the FIFO has overflowed.
`timescale 1ns/1ps
module daq_frame_sequencer
  import daq_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 24,
  parameter int unsigned PACE_LOG2     = 5,
  parameter logic [31:0] HEAD_WORD     = DEF_HEAD_WORD,
  parameter logic [31:0] TAIL_WORD     = DEF_TAIL_WORD
) (
  input  logic        bus_clk,
  input  logic        rst_n,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_byte,
  input  logic        stream_open,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic [31:0] fifo_din,
  output logic        fifo_wr_en,
  output logic        stream_eof,
  output logic        running,
  output logic [15:0] frame_count,
  output logic        led_active
);

  state_t     state;
  logic [7:0] word_idx;
  logic       close_pending;
  logic       open_d;
  logic       tick;
  logic       has_been_full;
  logic       overflow_stop;
  logic       cmd_start, cmd_reset, cmd_close;
  logic       open_fall, slot, last_payload;

  daq_pacer #(.PACE_LOG2(PACE_LOG2)) u_pacer (
    .bus_clk (bus_clk),
    .rst_n   (rst_n),
    .tick    (tick)
  );

`ifdef DAQ_OVERFLOW_STOP_EN
  logic has_been_nonfull;

  always_ff @(posedge bus_clk) begin
    if (!rst_n || !stream_open) begin
      has_been_nonfull <= 1'b0;
      has_been_full    <= 1'b0;
    end else begin
      if (!fifo_full)                     has_been_nonfull <= 1'b1;
      if (fifo_full && has_been_nonfull)  has_been_full    <= 1'b1;
    end
  end

  assign overflow_stop = has_been_full;
`else
  assign has_been_full = 1'b0;
  assign overflow_stop = 1'b0;
`endif

  assign cmd_start    = cmd_wr && (cmd_byte == CMD_START);
  assign cmd_reset    = cmd_wr && (cmd_byte == CMD_RESET);
  assign cmd_close    = cmd_wr && (cmd_byte == CMD_CLOSE);
  assign open_fall    = open_d && !stream_open;
  assign slot         = tick && (state != ST_IDLE) && stream_open && !fifo_full && !overflow_stop;
  assign last_payload = (word_idx == 8'(PAYLOAD_WORDS - 1));

  always_ff @(posedge bus_clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      word_idx      <= '0;
      close_pending <= 1'b0;
      open_d        <= 1'b0;
      fifo_din      <= '0;
      fifo_wr_en    <= 1'b0;
      stream_eof    <= 1'b0;
      frame_count   <= '0;
    end else begin
      open_d     <= stream_open;
      fifo_wr_en <= 1'b0;
      stream_eof <= fifo_empty && has_been_full;
      // Aborts take priority over any slot in the same cycle so no partial word escapes.
      if (cmd_reset) begin
        state         <= ST_IDLE;
        word_idx      <= '0;
        close_pending <= 1'b0;
        frame_count   <= '0;
      end else if (open_fall || overflow_stop) begin
        state         <= ST_IDLE;
        word_idx      <= '0;
        close_pending <= 1'b0;
      end else begin
        if (cmd_close && state != ST_IDLE) close_pending <= 1'b1;
        if (cmd_start && state == ST_IDLE) state <= ST_HEAD;
        if (slot) begin
          fifo_wr_en <= 1'b1;
          case (state)
            ST_HEAD: begin
              fifo_din <= HEAD_WORD;
              word_idx <= '0;
              state    <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
              fifo_din <= payload_word(word_idx);
              if (last_payload) state <= ST_TAIL;
              else              word_idx <= word_idx + 8'd1;
            end
            ST_TAIL: begin
              fifo_din    <= TAIL_WORD;
              frame_count <= frame_count + 16'd1;
              if (close_pending) begin
                state         <= ST_IDLE;
                close_pending <= 1'b0;
              end else begin
                state <= ST_HEAD;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign running    = (state != ST_IDLE);
  assign led_active = fifo_wr_en;

endmodule

// File: tb/tb_daq_frame_sequencer.sv
// Scoreboard bench for daq_frame_sequencer: expected FIFO words are queued at stimulus time.
`timescale 1ns/1ps
module tb_daq_frame_sequencer;

  localparam int unsigned PW  = 24;
  localparam int unsigned PL2 = 5;
  localparam logic [31:0] HEAD = 32'hAAAAAAAA;
  localparam logic [31:0] TAIL = 32'hF0F0F0F0;
  localparam logic [7:0]  C_START = 8'hFF;
  localparam logic [7:0]  C_RESET = 8'hC0;
  localparam logic [7:0]  C_CLOSE = 8'hC7;
  localparam int          SLOT = 1 << PL2;

  logic        bus_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic        stream_open = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_din;
  logic        fifo_wr_en;
  logic        stream_eof;
  logic        running;
  logic [15:0] frame_count;
  logic        led_active;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  int          wr_seen = 0;
  int          spurious = 0;
  longint      cyc = 0;
  longint      last_wr = 0;
  bit          chk_gap = 0;
  bit          gap_ok = 0;
  int          base;

  daq_frame_sequencer #(
    .PAYLOAD_WORDS (PW),
    .PACE_LOG2     (PL2),
    .HEAD_WORD     (HEAD),
    .TAIL_WORD     (TAIL)
  ) dut (
    .bus_clk     (bus_clk),
    .rst_n       (rst_n),
    .cmd_wr      (cmd_wr),
    .cmd_byte    (cmd_byte),
    .stream_open (stream_open),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .fifo_din    (fifo_din),
    .fifo_wr_en  (fifo_wr_en),
    .stream_eof  (stream_eof),
    .running     (running),
    .frame_count (frame_count),
    .led_active  (led_active)
  );

  always #5 bus_clk = ~bus_clk;
  always @(posedge bus_clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge bus_clk) begin
    if (fifo_wr_en) begin
      check("led_active", 32'(led_active), 32'd1);
      if (chk_gap) begin
        if (gap_ok) check("slot_gap", 32'(cyc - last_wr), 32'(SLOT));
        gap_ok = 1;
      end
      last_wr = cyc;
      wr_seen++;
      if (exp_q.size() == 0) spurious++;
      else check("fifo_din", fifo_din, exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge bus_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_byte = c;
    cmd_wr   = 1'b1;
    tick(1);
    cmd_wr   = 1'b0;
  endtask

  task automatic push_frame();
    exp_q.push_back(HEAD);
    for (int k = 0; k < int'(PW); k++) exp_q.push_back({16'(2 * k + 1), 16'(2 * k + 2)});
    exp_q.push_back(TAIL);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int i;
    i = 0;
    while (wr_seen < n && i < budget) begin
      tick(1);
      i++;
    end
    check("write_count", 32'(wr_seen), 32'(n));
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      tick(1);
      i++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tick(3);
    check("rst_din", fifo_din, 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_frames", 32'(frame_count), 32'd0);
    check("rst_eof", 32'(stream_eof), 32'd0);
    check("rst_led", 32'(led_active), 32'd0);
    rst_n = 1'b1;
    stream_open = 1'b1;
    tick(2);

    // Continuous frame with slot spacing, then the start of the next frame.
    chk_gap = 1; gap_ok = 0;
    push_frame();
    exp_q.push_back(HEAD);
    send_cmd(C_START);
    check("running", 32'(running), 32'd1);
    wait_writes(27, 27 * SLOT + 100);
    check("frames_t1", 32'(frame_count), 32'd1);
    chk_gap = 0;

    // Reset command mid-frame.
    send_cmd(C_RESET);
    tick(100);
    check("rcmd_frames", 32'(frame_count), 32'd0);
    check("rcmd_running", 32'(running), 32'd0);
    check("rcmd_writes", 32'(wr_seen), 32'd27);

    // Close after the tenth payload word.
    base = wr_seen;
    push_frame();
    send_cmd(C_START);
    wait_writes(base + 11, 11 * SLOT + 100);
    send_cmd(C_CLOSE);
    wait_drain(16 * SLOT + 100);
    tick(1000);
    check("close_running", 32'(running), 32'd0);
    check("close_frames", 32'(frame_count), 32'd1);
    check("close_writes", 32'(wr_seen), 32'(base + 26));

`ifndef DAQ_OVERFLOW_STOP_EN
    // Back-pressure mid-payload: nothing lost, nothing duplicated.
    base = wr_seen;
    push_frame();
    send_cmd(C_START);
    send_cmd(C_CLOSE);
    wait_writes(base + 9, 9 * SLOT + 100);
    fifo_full = 1'b1;
    tick(200);
    check("full_stall", 32'(wr_seen), 32'(base + 9));
    check("full_next", exp_q[0], 32'h00110012);
    fifo_full = 1'b0;
    wait_drain(18 * SLOT + 100);
    tick(100);
    check("full_total", 32'(wr_seen), 32'(base + 26));
    check("full_frames", 32'(frame_count), 32'd2);
`endif

    // Reset command mid-payload, then a clean frame.
    base = wr_seen;
    push_frame();
    send_cmd(C_START);
    wait_writes(base + 6, 6 * SLOT + 100);
    send_cmd(C_RESET);
    exp_q.delete();
    tick(200);
    check("rmid_writes", 32'(wr_seen), 32'(base + 6));
    check("rmid_frames", 32'(frame_count), 32'd0);
    push_frame();
    send_cmd(C_START);
    send_cmd(C_CLOSE);
    wait_drain(27 * SLOT + 100);
    tick(50);
    check("rmid_clean", 32'(frame_count), 32'd1);

    // Hardware reset pulse mid-frame.
    base = wr_seen;
    push_frame();
    send_cmd(C_START);
    wait_writes(base + 4, 4 * SLOT + 100);
    exp_q.delete();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("hrst_din", fifo_din, 32'd0);
    check("hrst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("hrst_running", 32'(running), 32'd0);
    check("hrst_frames", 32'(frame_count), 32'd0);
    check("hrst_eof", 32'(stream_eof), 32'd0);
    push_frame();
    send_cmd(C_START);
    send_cmd(C_CLOSE);
    wait_drain(27 * SLOT + 100);
    tick(40);
    check("hrst_clean", 32'(frame_count), 32'd1);

    // stream_open drops mid-frame: abort, frame_count kept.
    base = wr_seen;
    push_frame();
    send_cmd(C_START);
    wait_writes(base + 3, 3 * SLOT + 100);
    exp_q.delete();
    stream_open = 1'b0;
    tick(2);
    check("open_running", 32'(running), 32'd0);
    check("open_frames", 32'(frame_count), 32'd1);
    tick(100);
    check("open_writes", 32'(wr_seen), 32'(base + 3));
    stream_open = 1'b1;
    tick(2);

    // FIFO goes full after having been non-full.
    base = wr_seen;
    push_frame();
    send_cmd(C_START);
    send_cmd(C_CLOSE);
    wait_writes(base + 5, 5 * SLOT + 100);
    fifo_empty = 1'b0;
    fifo_full  = 1'b1;
    tick(100);
    check("ovf_stall", 32'(wr_seen), 32'(base + 5));
`ifdef DAQ_OVERFLOW_STOP_EN
    exp_q.delete();
    fifo_full = 1'b0;
    tick(100);
    check("ovf_stopped", 32'(wr_seen), 32'(base + 5));
    check("ovf_running", 32'(running), 32'd0);
    check("ovf_eof_pre", 32'(stream_eof), 32'd0);
    fifo_empty = 1'b1;
    tick(1);
    check("ovf_eof", 32'(stream_eof), 32'd1);
`else
    fifo_full = 1'b0;
    wait_drain(22 * SLOT + 100);
    fifo_empty = 1'b1;
    tick(3);
    check("ovf_eof", 32'(stream_eof), 32'd0);
    check("ovf_total", 32'(wr_seen), 32'(base + 26));
`endif

    tick(10);
    check("spurious", 32'(spurious), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
